// File: rtl/sdram_types.sv
// sdram_types
//   Shared types for the SDRAM controller. cmd_t and data_t are the
//   command encoding consumed by the SDRAM I/O stage. The scheduler
//   reuses that encoding unchanged. sdram_req_t is the scheduler's
//   request holding register, and sched_state_t is its FSM state.
//   NOP_WORD is the value driven on the command bus when nothing is issued.
//   There are no ports; this file only holds type and constant declarations.

package sdram_types;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_READ  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_PALL  = 3'd5,
    CMD_REF   = 3'd6,
    CMD_MRS   = 3'd7
  } cmd_t;

  typedef struct packed {
    logic [8:0]  column;
    logic [15:0] data;
  } cmd_payload_t;

  typedef struct packed {
    cmd_t         cmd;
    logic [1:0]   ba;
    cmd_payload_t d;
  } data_t;

  // The id field is sized for the widest legal tag. Narrower tags are
  // zero-extended when captured.
  typedef struct packed {
    logic        we;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] data;
    logic [15:0] id;
  } sdram_req_t;

  localparam data_t NOP_WORD = '{cmd: CMD_NOP, ba: 2'b00,
                                 d: '{column: 9'd0, data: 16'd0}};

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PALL,
    ST_INIT_REF,
    ST_INIT_MRS,
    ST_IDLE,
    ST_RF_PALL,
    ST_RF_REF,
    ST_PRE,
    ST_ACT,
    ST_RW
  } sched_state_t;

endpackage

// File: rtl/sdram_sched_row_tracker.sv
// sdram_row_tracker
//   Per-bank open-row bookkeeping for the open-page policy. It holds four
//   open bits and four 13-bit row registers. A query on one bank returns
//   whether that bank is open and whether its open row matches.
//   The module exists only when SDRAM_OPEN_PAGE_EN is defined. The
//   closed-page build neither needs it nor elaborates it.
// Ports:
//   clk, reset      : clock and synchronous active-high clear
//   i_set           : record i_setRow as the open row of bank i_setBa
//   i_setBa/i_setRow: bank and row to record
//   i_clrAll        : close every bank (after refresh)
//   i_qBa/i_qRow    : bank and row being queried
//   o_open          : queried bank is open
//   o_hit           : queried bank is open on the queried row

`ifdef SDRAM_OPEN_PAGE_EN
module sdram_row_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_set,
  input  logic [1:0]  i_setBa,
  input  logic [12:0] i_setRow,
  input  logic        i_clrAll,
  input  logic [1:0]  i_qBa,
  input  logic [12:0] i_qRow,
  output logic        o_open,
  output logic        o_hit
);

  logic [3:0]  r_open;
  logic [12:0] r_row [4];

  // A clear and a set never occur in the same cycle, because the
  // scheduler is in a single state. Clear is given priority anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_open <= 4'b0000;
      for (int b = 0; b < 4; b++) r_row[b] <= 13'd0;
    end else if (i_clrAll) begin
      r_open <= 4'b0000;
    end else if (i_set) begin
      r_open[i_setBa] <= 1'b1;
      r_row[i_setBa]  <= i_setRow;
    end
  end

  assign o_open = r_open[i_qBa];
  assign o_hit  = r_open[i_qBa] && (r_row[i_qBa] == i_qRow);

endmodule
`endif

// File: rtl/sdram_sched.sv
// sdram_sched
//   This block converts single-word read and write requests into SDRAM
//   command words: PRE, ACT, READ and WRITE. It also inserts the power-up
//   initialisation (PALL, INIT_REF x REF, MRS) and periodic refresh
//   (PALL, REF). It writes at most one command per cycle into the command
//   FIFO. Only the command order is enforced here. The I/O stage applies
//   the command timing.
// Configuration macro: SDRAM_OPEN_PAGE_EN
//   defined   : open-page policy. Rows stay open, and hits skip ACT.
//   undefined : closed-page policy. Every access is ACT, R/W, PRE.
// Ports:
//   clkSDRAM, reset   : clock, synchronous active-high reset
//   icnt_ovf          : init/refresh counter pulse from the I/O stage
//   req_valid/ready   : request handshake
//   req_we/ba/row/col : request attributes
//   req_data, req_id  : write data and read tag
//   fifo_full         : command FIFO full
//   fifo_wrreq/in     : command FIFO write strobe and command word
//   init_done         : initialisation fully written to the FIFO

module sdram_sched
  import sdram_types::*;
#(
  parameter int IN       = 4,
  parameter int INIT_REF = 8
) (
  input  logic          clkSDRAM,
  input  logic          reset,
  input  logic          icnt_ovf,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_ba,
  input  logic [12:0]   req_row,
  input  logic [8:0]    req_col,
  input  logic [15:0]   req_data,
  input  logic [IN-1:0] req_id,
  input  logic          fifo_full,
  output logic          fifo_wrreq,
  output data_t         fifo_in,
  output logic          init_done
);

  localparam int RCW = (INIT_REF > 1) ? $clog2(INIT_REF) : 1;

  sched_state_t   r_state;
  sched_state_t   w_nextState;
  sdram_req_t     r_req;
  logic           r_refreshPending;
  logic [RCW-1:0] r_refCnt;
  logic           r_initDone;
  logic           w_emit;
  logic           w_write;
  logic           w_accept;
  data_t          w_word;

  // If a counter pulse arrives in the same cycle as a request, the
  // request is refused. Refresh therefore wins even before the pending
  // flag is registered.
  assign req_ready  = (r_state == ST_IDLE) && !r_refreshPending && !icnt_ovf;
  assign w_accept   = req_valid && req_ready;
  assign fifo_wrreq = w_emit && !fifo_full;
  assign w_write    = fifo_wrreq;
  assign fifo_in    = w_word;
  assign init_done  = r_initDone;

`ifdef SDRAM_OPEN_PAGE_EN
  logic w_open;
  logic w_hit;

  sdram_row_tracker u_rowTracker (
    .clk      (clkSDRAM),
    .reset    (reset),
    .i_set    ((r_state == ST_ACT) && w_write),
    .i_setBa  (r_req.ba),
    .i_setRow (r_req.row),
    .i_clrAll ((r_state == ST_RF_REF) && w_write),
    .i_qBa    (req_ba),
    .i_qRow   (req_row),
    .o_open   (w_open),
    .o_hit    (w_hit)
  );
`endif

  // State register
  always_ff @(posedge clkSDRAM) begin
    if (reset) r_state <= ST_INIT_WAIT;
    else       r_state <= w_nextState;
  end

  // Request holding register, refresh flag, init REF counter, init_done.
  // The first icnt_ovf in INIT_WAIT only starts initialisation. Every
  // later pulse requests a refresh, including a pulse that lands in the
  // same cycle as the refresh REF that would otherwise clear the flag.
  always_ff @(posedge clkSDRAM) begin
    if (reset) begin
      r_req            <= '0;
      r_refreshPending <= 1'b0;
      r_refCnt         <= '0;
      r_initDone       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.we   <= req_we;
        r_req.ba   <= req_ba;
        r_req.row  <= req_row;
        r_req.col  <= req_col;
        r_req.data <= req_data;
        r_req.id   <= 16'(req_id);
      end
      if (icnt_ovf && (r_state != ST_INIT_WAIT))
        r_refreshPending <= 1'b1;
      else if ((r_state == ST_RF_REF) && w_write)
        r_refreshPending <= 1'b0;
      if ((r_state == ST_INIT_REF) && w_write)
        r_refCnt <= r_refCnt + RCW'(1);
      if ((r_state == ST_INIT_MRS) && w_write)
        r_initDone <= 1'b1;
    end
  end

  // Next-state logic. Any state that emits a command moves on only after
  // its word is actually written, so fifo_full simply freezes the FSM.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_INIT_WAIT: if (icnt_ovf) w_nextState = ST_INIT_PALL;
      ST_INIT_PALL: if (w_write) w_nextState = ST_INIT_REF;
      ST_INIT_REF:  if (w_write && (r_refCnt == RCW'(INIT_REF - 1)))
                      w_nextState = ST_INIT_MRS;
      ST_INIT_MRS:  if (w_write) w_nextState = ST_IDLE;
      ST_IDLE: begin
        if (r_refreshPending) begin
          w_nextState = ST_RF_PALL;
        end else if (w_accept) begin
`ifdef SDRAM_OPEN_PAGE_EN
          if (w_hit)       w_nextState = ST_RW;
          else if (w_open) w_nextState = ST_PRE;
          else             w_nextState = ST_ACT;
`else
          w_nextState = ST_ACT;
`endif
        end
      end
      ST_RF_PALL: if (w_write) w_nextState = ST_RF_REF;
      ST_RF_REF:  if (w_write) w_nextState = ST_IDLE;
`ifdef SDRAM_OPEN_PAGE_EN
      ST_PRE:     if (w_write) w_nextState = ST_ACT;
      ST_RW:      if (w_write) w_nextState = ST_IDLE;
`else
      ST_PRE:     if (w_write) w_nextState = ST_IDLE;
      ST_RW:      if (w_write) w_nextState = ST_PRE;
`endif
      ST_ACT:     if (w_write) w_nextState = ST_RW;
      default:    w_nextState = ST_INIT_WAIT;
    endcase
  end

  // Command decode. This uses only registered state and the holding
  // register, so there is no path from req_* to the FIFO interface.
  always_comb begin
    w_emit = 1'b0;
    w_word = NOP_WORD;
    case (r_state)
      ST_INIT_PALL, ST_RF_PALL: begin
        w_emit     = 1'b1;
        w_word.cmd = CMD_PALL;
      end
      ST_INIT_REF, ST_RF_REF: begin
        w_emit     = 1'b1;
        w_word.cmd = CMD_REF;
      end
      ST_INIT_MRS: begin
        w_emit     = 1'b1;
        w_word.cmd = CMD_MRS;
      end
      ST_PRE: begin
        w_emit     = 1'b1;
        w_word.cmd = CMD_PRE;
        w_word.ba  = r_req.ba;
      end
      ST_ACT: begin
        w_emit        = 1'b1;
        w_word.cmd    = CMD_ACT;
        w_word.ba     = r_req.ba;
        w_word.d.data = {3'b000, r_req.row};
      end
      ST_RW: begin
        w_emit          = 1'b1;
        w_word.cmd      = r_req.we ? CMD_WRITE : CMD_READ;
        w_word.ba       = r_req.ba;
        w_word.d.column = r_req.col;
        w_word.d.data   = r_req.we ? r_req.data : r_req.id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_sched.sv
module tb_sdram_sched;
  import sdram_types::*;

  localparam int IN       = 4;
  localparam int INIT_REF = 8;

  logic          clkSDRAM = 1'b0;
  logic          reset;
  logic          icnt_ovf;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_ba;
  logic [12:0]   req_row;
  logic [8:0]    req_col;
  logic [15:0]   req_data;
  logic [IN-1:0] req_id;
  logic          fifo_full;
  logic          fifo_wrreq;
  data_t         fifo_in;
  logic          init_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  data_t       expQ[$];
  int          wrCyc[$];
  bit          mOpen[4];
  logic [12:0] mRow[4];

  sdram_sched #(.IN(IN), .INIT_REF(INIT_REF)) dut (
    .clkSDRAM   (clkSDRAM),
    .reset      (reset),
    .icnt_ovf   (icnt_ovf),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_ba     (req_ba),
    .req_row    (req_row),
    .req_col    (req_col),
    .req_data   (req_data),
    .req_id     (req_id),
    .fifo_full  (fifo_full),
    .fifo_wrreq (fifo_wrreq),
    .fifo_in    (fifo_in),
    .init_done  (init_done)
  );

  always #5 clkSDRAM = ~clkSDRAM;

  always @(posedge clkSDRAM) cyc <= cyc + 1;

  function automatic data_t mk(cmd_t c, logic [1:0] ba, logic [8:0] col, logic [15:0] dat);
    data_t w;
    w.cmd      = c;
    w.ba       = ba;
    w.d.column = col;
    w.d.data   = dat;
    return w;
  endfunction

  // Scoreboard: every write the DUT makes is popped and compared in order
  always @(negedge clkSDRAM) begin
    data_t e;
    if (fifo_wrreq === 1'b1) begin
      wrCyc.push_back(cyc);
      tests++;
      if (fifo_full === 1'b1) begin
        fails++;
        $display("[TB] FAIL wrreq_while_full: fifo_wrreq=1 with fifo_full=1 at cycle %0d", cyc);
      end else if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: got %h, expected no write (cycle %0d)", fifo_in, cyc);
      end else begin
        e = expQ.pop_front();
        if (fifo_in !== e) begin
          fails++;
          $display("[TB] FAIL cmd_word: got %h, expected %h (cycle %0d)", fifo_in, e, cyc);
        end
      end
    end
  end

  task automatic clearModel();
    for (int b = 0; b < 4; b++) begin
      mOpen[b] = 1'b0;
      mRow[b]  = 13'd0;
    end
  endtask

  task automatic pushReq(input logic we, input logic [1:0] ba, input logic [12:0] row,
                         input logic [8:0] col, input logic [15:0] dat,
                         input logic [IN-1:0] id, output int n);
    data_t rw;
    rw = we ? mk(CMD_WRITE, ba, col, dat) : mk(CMD_READ, ba, col, 16'(id));
`ifdef SDRAM_OPEN_PAGE_EN
    if (mOpen[ba] && (mRow[ba] == row)) begin
      expQ.push_back(rw);
      n = 1;
    end else begin
      if (mOpen[ba]) begin
        expQ.push_back(mk(CMD_PRE, ba, 9'd0, 16'd0));
        n = 3;
      end else begin
        n = 2;
      end
      expQ.push_back(mk(CMD_ACT, ba, 9'd0, {3'b000, row}));
      expQ.push_back(rw);
    end
    mOpen[ba] = 1'b1;
    mRow[ba]  = row;
`else
    expQ.push_back(mk(CMD_ACT, ba, 9'd0, {3'b000, row}));
    expQ.push_back(rw);
    expQ.push_back(mk(CMD_PRE, ba, 9'd0, 16'd0));
    n = 3;
`endif
  endtask

  // Drive one request, optionally together with a counter pulse and/or a
  // full FIFO, and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input logic we, input logic [1:0] ba, input logic [12:0] row,
                               input logic [8:0] col, input logic [15:0] dat,
                               input logic [IN-1:0] id, input bit withOvf, input bit full,
                               output int accCyc, output int n, output int preWrites);
    int t;
    @(posedge clkSDRAM); #1;
    if (withOvf) begin
      expQ.push_back(mk(CMD_PALL, 2'd0, 9'd0, 16'd0));
      expQ.push_back(mk(CMD_REF, 2'd0, 9'd0, 16'd0));
      clearModel();
    end
    pushReq(we, ba, row, col, dat, id, n);
    wrCyc.delete();
    req_we = we; req_ba = ba; req_row = row; req_col = col; req_data = dat; req_id = id;
    req_valid = 1'b1;
    icnt_ovf  = withOvf;
    fifo_full = full;
    accCyc = -1;
    preWrites = 0;
    t = 0;
    while (accCyc < 0 && t < 50) begin
      @(negedge clkSDRAM); #1;
      if (req_ready === 1'b1) begin
        accCyc = cyc;
        preWrites = wrCyc.size();
      end else begin
        @(posedge clkSDRAM); #1;
        icnt_ovf = 1'b0;
        t++;
      end
    end
    tests++;
    if (accCyc < 0) begin
      fails++;
      $display("[TB] FAIL accept_timeout: req_ready never 1 within %0d cycles, expected accept", t);
    end
    @(posedge clkSDRAM); #1;
    req_valid = 1'b0;
    icnt_ovf  = 1'b0;
  endtask

  // Wait for the expected words to drain, then check the count, latency
  // and back-to-back issue, and that req_ready is high in the following cycle.
  task automatic checkOutput(input string name, input int n, input int accCyc,
                             input int firstLat, input int preWrites);
    int t;
    t = 0;
    while (expQ.size() != 0 && t < 60) begin
      @(negedge clkSDRAM); #1;
      t++;
    end
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_drain: %0d words still outstanding, expected 0", name, expQ.size());
      expQ.delete();
    end
    repeat (preWrites) if (wrCyc.size() > 0) void'(wrCyc.pop_front());
    tests++;
    if (wrCyc.size() != n) begin
      fails++;
      $display("[TB] FAIL %s_count: got %0d writes, expected %0d", name, wrCyc.size(), n);
    end else begin
      tests++;
      if (wrCyc[0] != accCyc + firstLat) begin
        fails++;
        $display("[TB] FAIL %s_latency: first write at +%0d, expected +%0d", name,
                 wrCyc[0] - accCyc, firstLat);
      end
      tests++;
      if (wrCyc[$] - wrCyc[0] != n - 1) begin
        fails++;
        $display("[TB] FAIL %s_spacing: span %0d cycles, expected %0d", name,
                 wrCyc[$] - wrCyc[0], n - 1);
      end
    end
    @(negedge clkSDRAM); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s_ready_after: req_ready=%b, expected 1", name, req_ready);
    end
  endtask

  task automatic runInit(input string name);
    int t;
    wrCyc.delete();
    expQ.push_back(mk(CMD_PALL, 2'd0, 9'd0, 16'd0));
    repeat (INIT_REF) expQ.push_back(mk(CMD_REF, 2'd0, 9'd0, 16'd0));
    expQ.push_back(mk(CMD_MRS, 2'd0, 9'd0, 16'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clkSDRAM); #1;
      tests++;
      if (fifo_wrreq !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL %s_wait_quiet: wrreq=%b ready=%b, expected 0 0", name, fifo_wrreq, req_ready);
      end
    end
    @(posedge clkSDRAM); #1 icnt_ovf = 1'b1;
    @(posedge clkSDRAM); #1 icnt_ovf = 1'b0;
    t = 0;
    while (init_done !== 1'b1 && t < 40) begin
      @(negedge clkSDRAM); #1;
      t++;
    end
    tests++;
    if (init_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s_init_done: init_done=%b, expected 1", name, init_done);
    end
    tests++;
    if (wrCyc.size() != INIT_REF + 2) begin
      fails++;
      $display("[TB] FAIL %s_count: got %0d writes, expected %0d", name, wrCyc.size(), INIT_REF + 2);
    end else begin
      tests++;
      if (wrCyc[$] - wrCyc[0] != INIT_REF + 1) begin
        fails++;
        $display("[TB] FAIL %s_consecutive: span %0d, expected %0d", name,
                 wrCyc[$] - wrCyc[0], INIT_REF + 1);
      end
    end
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_leftover: %0d words not seen, expected 0", name, expQ.size());
      expQ.delete();
    end
    @(negedge clkSDRAM); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s_ready: req_ready=%b, expected 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; icnt_ovf = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_ba = 2'd0;
    req_row = 13'd0; req_col = 9'd0; req_data = 16'd0; req_id = '0; fifo_full = 1'b0;
    clearModel();
    repeat (2) @(posedge clkSDRAM);
    @(negedge clkSDRAM); #1;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b, expected 0", req_ready); end
    tests++;
    if (fifo_wrreq !== 1'b0) begin fails++; $display("[TB] FAIL reset_wrreq: got %b, expected 0", fifo_wrreq); end
    tests++;
    if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_init_done: got %b, expected 0", init_done); end
    tests++;
    if (fifo_in !== NOP_WORD) begin fails++; $display("[TB] FAIL reset_fifo_in: got %h, expected %h", fifo_in, NOP_WORD); end
    @(posedge clkSDRAM); #1 reset = 1'b0;
  endtask

  task automatic test_init();
    runInit("init");
  endtask

  task automatic test_closed_then_hit();
    int acc, n, pw;
    applyStimulus(1'b1, 2'd1, 13'h0123, 9'h010, 16'hBEEF, 4'd0, 1'b0, 1'b0, acc, n, pw);
    checkOutput("closed_write", n, acc, 1, pw);
    applyStimulus(1'b0, 2'd1, 13'h0123, 9'h011, 16'h0000, 4'd5, 1'b0, 1'b0, acc, n, pw);
    checkOutput("hit_read", n, acc, 1, pw);
  endtask

  task automatic test_row_miss();
    int acc, n, pw;
    applyStimulus(1'b1, 2'd1, 13'h0124, 9'h020, 16'h1234, 4'd0, 1'b0, 1'b0, acc, n, pw);
    checkOutput("row_miss", n, acc, 1, pw);
  endtask

  task automatic test_refresh_vs_request();
    int acc, n, pw;
    applyStimulus(1'b0, 2'd1, 13'h0124, 9'h030, 16'h0000, 4'd9, 1'b1, 1'b0, acc, n, pw);
    tests++;
    if (pw != 2) begin
      fails++;
      $display("[TB] FAIL refresh_first: %0d writes before accept, expected 2", pw);
    end
    checkOutput("after_refresh", n, acc, 1, pw);
  endtask

  task automatic test_backpressure();
    int acc, n, pw;
    data_t held;
    applyStimulus(1'b1, 2'd2, 13'h0005, 9'h044, 16'hA5A5, 4'd0, 1'b0, 1'b1, acc, n, pw);
    held = expQ[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clkSDRAM); #1;
      tests++;
      if (fifo_wrreq !== 1'b0 || fifo_in !== held) begin
        fails++;
        $display("[TB] FAIL stall_%0d: wrreq=%b word=%h, expected 0 %h", i, fifo_wrreq, fifo_in, held);
      end
    end
    @(posedge clkSDRAM); #1 fifo_full = 1'b0;
    checkOutput("backpressure", n, acc, 6, pw);
  endtask

  task automatic test_reset_mid_access();
    int acc, n, pw;
    applyStimulus(1'b0, 2'd2, 13'h0006, 9'h050, 16'h0000, 4'd3, 1'b0, 1'b0, acc, n, pw);
    reset = 1'b1;
    @(negedge clkSDRAM); #1;
    @(negedge clkSDRAM); #1;
    tests++;
    if (wrCyc.size() != 1) begin
      fails++;
      $display("[TB] FAIL midreset_partial: got %0d writes, expected 1", wrCyc.size());
    end
    tests++;
    if (fifo_wrreq !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: wrreq=%b ready=%b init_done=%b, expected 0 0 0",
               fifo_wrreq, req_ready, init_done);
    end
    expQ.delete();
    clearModel();
    @(posedge clkSDRAM); #1 reset = 1'b0;
    runInit("reinit");
    applyStimulus(1'b0, 2'd2, 13'h0006, 9'h050, 16'h0000, 4'd3, 1'b0, 1'b0, acc, n, pw);
    checkOutput("post_reset", n, acc, 1, pw);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_init();
    test_closed_then_hit();
    test_row_miss();
    test_refresh_vs_request();
    test_backpressure();
    test_reset_mid_access();
    repeat (3) @(negedge clkSDRAM);
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL final_queue: %0d words outstanding, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_sched.md
# sdram_sched

Request-to-command scheduler for the SDRAM controller. Accepts single-word read and write requests from the arbiter side. Translates each one into the SDRAM command sequence (PRE/ACT/READ/WRITE), inserts the power-up initialisation sequence and periodic refresh, and pushes one `data_t` command per cycle into the command FIFO that the SDRAM I/O stage drains. Command timing (tRCD, tRP, tRC, …) is enforced downstream by the I/O stage. This block only guarantees legal command ordering.

## Interface
Parameters:
- `IN`, 4: request ID width; must be ≤ 16.
- `INIT_REF`, 8: number of REF commands issued during initialisation.

Ports:
- `clkSDRAM`, in, 1: controller clock.
- `reset`, in, 1: synchronous, active-high reset.
- `icnt_ovf`, in, 1: one-cycle pulse from the I/O stage's init/refresh counter.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted when `req_valid && req_ready`.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_ba`, in, 2: bank.
- `req_row`, in, 13: row.
- `req_col`, in, 9: column.
- `req_data`, in, 16: write data; ignored for reads.
- `req_id`, in, `IN`: read tag; returned by the I/O stage with the read data.
- `fifo_full`, in, 1: command FIFO full.
- `fifo_wrreq`, out, 1: command FIFO write strobe.
- `fifo_in`, out, `data_t`: command word.
- `init_done`, out, 1: initialisation sequence fully written to the FIFO.

## Operation
Command word encoding, per command:
- ACT: `ba`, with `d.data[12:0]` = row.
- READ: `ba`, `d.column`, with `d.data[IN-1:0]` = `req_id`.
- WRITE: `ba`, `d.column`, with `d.data` = `req_data`.
- PRE: `ba`.
- PALL, REF, MRS: `ba` = 0 and `d` = 0.

FSM states: INIT_WAIT, INIT_PALL, INIT_REF, INIT_MRS, IDLE, RF_PALL, RF_REF, PRE, ACT, RW.
- **Reset:** state goes to INIT_WAIT. All bank-open bits, `refresh_pending` and the REF counter are cleared.
- **INIT_WAIT:** the first `icnt_ovf` moves the FSM to INIT_PALL. That pulse does not set `refresh_pending`.
- **Initialisation:** INIT_PALL → INIT_REF (`INIT_REF` REF commands) → INIT_MRS → IDLE. `init_done` is set when MRS is written and stays high until reset.
- **Refresh request:** any `icnt_ovf` after INIT_WAIT sets `refresh_pending`. This includes pulses that arrive during the init sequence, during refresh, or during an access.
- **IDLE:** if `refresh_pending`, go to RF_PALL, emit PALL, then RF_REF, emit one REF. Clear all open bits and `refresh_pending` when the REF is written. A new `icnt_ovf` in that same cycle leaves `refresh_pending` set. Otherwise `req_ready` = 1.
- **On request accept:** capture the request into a holding register, then select the next state:
  - bank open with the same row (hit): RW.
  - bank open with a different row: PRE → ACT → RW.
  - bank closed: ACT → RW.
- **ACT write:** when the ACT command is written to the FIFO, record `req_row` for the bank and set its open bit.
- **RW write:** when the RW command is written to the FIFO, return to IDLE.
- **Command emission:**
  - A state that emits a command holds `fifo_wrreq` = `~fifo_full` and `fifo_in` stable until the write occurs.
  - The state advances only on a write.
  - `fifo_full` stalls the FSM indefinitely with no loss or duplication.
- **Idle output:** in IDLE and INIT_WAIT, `fifo_wrreq` = 0.
- **Refresh priority:** refresh always wins over a simultaneous request. `req_ready` is 0 whenever `refresh_pending` is set.

## Timing
- **Reset values:** `req_ready` = 0, `fifo_wrreq` = 0, `init_done` = 0, `fifo_in` = NOP word.
- **Outputs:** `fifo_in` and `fifo_wrreq` are decoded from registered state only. There is no combinational path from `req_*` to `fifo_*`. `fifo_wrreq` depends combinationally on `fifo_full`.
- **Latency from accept at cycle 0, with FIFO never full:**
  - hit: WRITE/READ in cycle 1.
  - closed bank: ACT in cycle 1, R/W in cycle 2.
  - row miss: PRE in cycle 1, ACT in cycle 2, R/W in cycle 3.
  - `req_ready` is high again in the cycle after the R/W write.
- **Refresh:** PALL and REF in consecutive cycles.
- **Initialisation:** `INIT_REF` + 2 FIFO writes after the first `icnt_ovf`.
- **Reset mid-sequence:** reset asserted during any state returns to INIT_WAIT at the next edge. A partially issued sequence is abandoned.

## Configuration
- **`SDRAM_OPEN_PAGE_EN` defined:** open-page policy as described in Operation.
- **`SDRAM_OPEN_PAGE_EN` undefined:** closed-page policy.
  - Every access is ACT → RW → PRE, and `req_ready` returns after the PRE write.
  - Open bits are never set.
  - The row tracker is not instantiated.

## Structure
- **`sdram_types` package:**
  - `cmd_t` and `data_t` stay here. The scheduler reuses the exact encoding consumed by the I/O stage.
  - Add `sdram_req_t`, packed: `we`, `ba`, `row`, `col`, `data`, `id`.
  - Add the localparam `NOP_WORD`.
- **Sub-module `sdram_row_tracker`:** four open bits and four 13-bit row registers.
  - Inputs: `set` (ba, row), `clr_all`.
  - Outputs: `hit`, `open`, each for a queried bank.
  - Synchronous clear on `reset`.

## Test plan
- **Initialisation:** reset, then pulse `icnt_ovf` with `fifo_full` = 0 → FIFO receives PALL, 8×REF, MRS on 10 consecutive cycles, then `init_done` = 1.
- **Closed bank, then hit:** write to ba 1, row 0x0123, col 0x010, data 0xBEEF into a closed bank → ACT(ba 1, row 0x0123), then WRITE(ba 1, col 0x010, data 0xBEEF). A following read of ba 1, row 0x0123, id 5 → READ only, one cycle after accept.
- **Row miss:** request to ba 1, row 0x0124 → PRE(ba 1), ACT(ba 1, row 0x0124), R/W, on cycles 1–3. Without the macro, every access ends with PRE(ba 1) and no PRE precedes ACT.
- **Refresh vs request:** `icnt_ovf` in the same cycle as `req_valid` → PALL, REF emitted first and `req_ready` stays 0 meanwhile. The request then goes out as ACT + R/W, because all rows were closed.
- **Back-pressure:** `fifo_full` held for 5 cycles mid-ACT → `fifo_wrreq` = 0 and `fifo_in` stable for those cycles; exactly one ACT is written after release.
- **Reset mid-access:** assert `reset` between PRE and ACT → next cycle `fifo_wrreq` = 0 and `req_ready` = 0. The FSM waits for `icnt_ovf` and reissues the full initialisation.
